// File: rtl/lp_dmem_pkg.sv
// lp_dmem_pkg: shared power states, default sizing and idle pin levels for the dmem controller
package lp_dmem_pkg;
    typedef enum logic [2:0] {
        ACTIVE = 3'd0,
        LSLP   = 3'd1,
        DSLP   = 3'd2,
        SHDN   = 3'd3,
        WAKE   = 3'd4
    } pwr_state_e;
    localparam int DEF_NUM_BANK = 48;
    localparam int DEF_LS_IDLE  = 8;
    localparam int DEF_DS_IDLE  = 64;
    localparam int DEF_WAKE_DS  = 2;
    localparam int DEF_WAKE_SD  = 4;
    localparam int DEF_CNT_W    = 8;
    localparam logic CSB_IDLE = 1'b1;
    localparam logic WEB_IDLE = 1'b1;
    localparam logic OEB_IDLE = 1'b1;
endpackage

// File: rtl/lp_dmem_port_seq.sv
// lp_dmem_port_seq: per-port SRAM pin register stage and 2-deep read-valid pipe
module lp_dmem_port_seq
    import lp_dmem_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_acc,
    input  logic         i_we,
    input  logic [4:0]   i_addr,
    input  logic [W-1:0] i_wdata,
    output logic         o_csb,
    output logic         o_web,
    output logic         o_oeb,
    output logic [4:0]   o_addr,
    output logic [W-1:0] o_wdata,
    output logic         o_rvalid
);
    logic         r_csb, r_web, r_oeb;
    logic [4:0]   r_addr;
    logic [W-1:0] r_wdata;
    logic [1:0]   r_rd;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_csb   <= CSB_IDLE;
            r_web   <= WEB_IDLE;
            r_oeb   <= OEB_IDLE;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rd    <= '0;
        end else begin
            r_csb <= i_acc ? 1'b0 : CSB_IDLE;
            r_web <= i_acc ? !i_we : WEB_IDLE;
            r_oeb <= i_acc ? i_we : OEB_IDLE;
            if (i_acc) begin
                r_addr  <= i_addr;
                r_wdata <= i_wdata;
            end
            r_rd <= {r_rd[0], i_acc & !i_we};
        end
    end
    assign o_csb    = r_csb;
    assign o_web    = r_web;
    assign o_oeb    = r_oeb;
    assign o_addr   = r_addr;
    assign o_wdata  = r_wdata;
    assign o_rvalid = r_rd[1];
endmodule

// File: rtl/lp_dmem_ctrl.sv
// lp_dmem_ctrl: dual-client access and sleep/shutdown sequencing for the LP data memory.
// Define LP_DMEM_CTRL_DS_EN to enable the deep-sleep state.
module lp_dmem_ctrl
    import lp_dmem_pkg::*;
#(
    parameter int NUM_BANK = DEF_NUM_BANK,
    parameter int LS_IDLE  = DEF_LS_IDLE,
    parameter int DS_IDLE  = DEF_DS_IDLE,
    parameter int WAKE_DS  = DEF_WAKE_DS,
    parameter int WAKE_SD  = DEF_WAKE_SD,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_a_valid,
    output logic                    o_a_ready,
    input  logic                    i_a_we,
    input  logic [4:0]              i_a_addr,
    input  logic [32*NUM_BANK-1:0]  i_a_wdata,
    output logic [32*NUM_BANK-1:0]  o_a_rdata,
    output logic                    o_a_rvalid,
    input  logic                    i_b_valid,
    output logic                    o_b_ready,
    input  logic                    i_b_we,
    input  logic [4:0]              i_b_addr,
    input  logic [32*NUM_BANK-1:0]  i_b_wdata,
    output logic [32*NUM_BANK-1:0]  o_b_rdata,
    output logic                    o_b_rvalid,
    input  logic                    i_shutdown_req,
    output logic [2:0]              o_pwr_state,
    output logic                    o_mem_lost,
    output logic                    o_m_sd,
    output logic                    o_m_ds,
    output logic                    o_m_ls,
    output logic                    o_m_csb1,
    output logic                    o_m_csb2,
    output logic                    o_m_web1,
    output logic                    o_m_web2,
    output logic                    o_m_oeb1,
    output logic                    o_m_oeb2,
    output logic [4:0]              o_m_a1,
    output logic [4:0]              o_m_a2,
    output logic [32*NUM_BANK-1:0]  o_m_i1,
    output logic [32*NUM_BANK-1:0]  o_m_i2,
    input  logic [32*NUM_BANK-1:0]  i_m_o1,
    input  logic [32*NUM_BANK-1:0]  i_m_o2
);
`ifdef LP_DMEM_CTRL_DS_EN
    localparam bit DS_EN = 1'b1;
`else
    localparam bit DS_EN = 1'b0;
`endif
    localparam logic [CNT_W-1:0] IDLE_MAX = CNT_W'(DS_EN ? DS_IDLE : LS_IDLE);
    localparam logic [CNT_W-1:0] LS_TH    = CNT_W'(LS_IDLE);
    pwr_state_e       r_state;
    logic [CNT_W-1:0] r_idle, r_wake, w_idle_nxt;
    logic             r_lost;
    logic             w_conf, w_acc_a, w_acc_b, w_any, w_wr;
    assign o_a_ready  = (r_state == ACTIVE) & !i_shutdown_req & !rst;
    assign w_conf     = i_a_valid & i_b_valid & (i_a_addr == i_b_addr) & (i_a_we | i_b_we);
    assign o_b_ready  = o_a_ready & !w_conf;
    assign w_acc_a    = i_a_valid & o_a_ready;
    assign w_acc_b    = i_b_valid & o_b_ready;
    assign w_any      = i_a_valid | i_b_valid;
    assign w_wr       = (w_acc_a & i_a_we) | (w_acc_b & i_b_we);
    // idle count only runs in the awake-or-light-sleep states and restarts on any accept
    assign w_idle_nxt = ((r_state != ACTIVE && r_state != LSLP) || w_acc_a || w_acc_b) ? '0 :
                        (r_idle == IDLE_MAX ? r_idle : r_idle + 1'b1);
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ACTIVE;
            r_idle  <= '0;
            r_wake  <= '0;
            r_lost  <= 1'b0;
        end else begin
            r_idle <= w_idle_nxt;
            r_lost <= i_shutdown_req | (r_lost & !w_wr);
            if (i_shutdown_req) r_state <= SHDN;
            else case (r_state)
                ACTIVE: if (w_idle_nxt >= LS_TH) r_state <= LSLP;
                LSLP: begin
                    if (w_any) r_state <= ACTIVE;
                    else if (DS_EN && w_idle_nxt == IDLE_MAX) r_state <= DSLP;
                end
                DSLP: if (w_any) begin
                    r_state <= WAKE;
                    r_wake  <= CNT_W'(WAKE_DS);
                end
                SHDN: begin
                    r_state <= WAKE;
                    r_wake  <= CNT_W'(WAKE_SD);
                end
                WAKE: begin
                    r_wake <= r_wake - 1'b1;
                    if (r_wake == CNT_W'(1)) r_state <= ACTIVE;
                end
                default: r_state <= ACTIVE;
            endcase
        end
    end
    assign o_pwr_state = r_state;
    assign o_mem_lost  = r_lost;
    assign o_m_ls      = r_state == LSLP;
    assign o_m_ds      = DS_EN & (r_state == DSLP);
    assign o_m_sd      = r_state == SHDN;
    assign o_a_rdata   = i_m_o1;
    assign o_b_rdata   = i_m_o2;
    lp_dmem_port_seq #(.W(32*NUM_BANK)) u_port1 (
        .clk(clk), .rst(rst), .i_acc(w_acc_a), .i_we(i_a_we), .i_addr(i_a_addr), .i_wdata(i_a_wdata),
        .o_csb(o_m_csb1), .o_web(o_m_web1), .o_oeb(o_m_oeb1), .o_addr(o_m_a1), .o_wdata(o_m_i1),
        .o_rvalid(o_a_rvalid)
    );
    lp_dmem_port_seq #(.W(32*NUM_BANK)) u_port2 (
        .clk(clk), .rst(rst), .i_acc(w_acc_b), .i_we(i_b_we), .i_addr(i_b_addr), .i_wdata(i_b_wdata),
        .o_csb(o_m_csb2), .o_web(o_m_web2), .o_oeb(o_m_oeb2), .o_addr(o_m_a2), .o_wdata(o_m_i2),
        .o_rvalid(o_b_rvalid)
    );
endmodule

// File: tb/tb_lp_dmem_ctrl.sv
// tb_lp_dmem_ctrl: directed and random bench for lp_dmem_ctrl with an SRAM model and scoreboard
module tb_lp_dmem_ctrl;
    localparam int NB = 2;
    localparam int W  = 32 * NB;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst, shutdown_req;
    logic a_valid, a_ready, a_we, a_rvalid, b_valid, b_ready, b_we, b_rvalid;
    logic [4:0] a_addr, b_addr, m_a1, m_a2;
    logic [W-1:0] a_wdata, b_wdata, a_rdata, b_rdata, m_i1, m_i2, o1, o2;
    logic [2:0] pwr_state;
    logic mem_lost, m_sd, m_ds, m_ls, m_csb1, m_csb2, m_web1, m_web2, m_oeb1, m_oeb2;
    int total = 0, bad = 0, cyc = 0;
    bit act;
    logic [W-1:0] mem [32];
    logic [W-1:0] ref_mem [32];
    bit ref_ok [32];
    typedef struct { int due; logic [W-1:0] d; bit ok; } rd_t;
    rd_t qa[$], qb[$];

    lp_dmem_ctrl #(.NUM_BANK(NB)) dut (
        .clk(clk), .rst(rst),
        .i_a_valid(a_valid), .o_a_ready(a_ready), .i_a_we(a_we), .i_a_addr(a_addr), .i_a_wdata(a_wdata),
        .o_a_rdata(a_rdata), .o_a_rvalid(a_rvalid),
        .i_b_valid(b_valid), .o_b_ready(b_ready), .i_b_we(b_we), .i_b_addr(b_addr), .i_b_wdata(b_wdata),
        .o_b_rdata(b_rdata), .o_b_rvalid(b_rvalid),
        .i_shutdown_req(shutdown_req), .o_pwr_state(pwr_state), .o_mem_lost(mem_lost),
        .o_m_sd(m_sd), .o_m_ds(m_ds), .o_m_ls(m_ls),
        .o_m_csb1(m_csb1), .o_m_csb2(m_csb2), .o_m_web1(m_web1), .o_m_web2(m_web2),
        .o_m_oeb1(m_oeb1), .o_m_oeb2(m_oeb2), .o_m_a1(m_a1), .o_m_a2(m_a2),
        .o_m_i1(m_i1), .o_m_i2(m_i2), .i_m_o1(o1), .i_m_o2(o2)
    );

    // dual-port SRAM: both ports sample on the clock edge, shutdown scrambles contents
    always @(posedge clk) begin
        if (m_sd) begin
            for (int k = 0; k < 32; k++) mem[k] <= {$urandom, $urandom};
        end else begin
            if (!m_csb1 && !m_web1) mem[m_a1] <= m_i1;
            if (!m_csb2 && !m_web2) mem[m_a2] <= m_i2;
            if (!m_csb1 && !m_oeb1) o1 <= mem[m_a1];
            if (!m_csb2 && !m_oeb2) o2 <= mem[m_a2];
        end
    end

    task automatic chkb(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%b exp=%b", tag, obs, exp);
        end
    endtask

    task automatic chkn(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_a(input bit v, input bit we, input logic [4:0] addr, input logic [W-1:0] d);
        a_valid = v; a_we = we; a_addr = addr; a_wdata = d;
    endtask

    task automatic set_b(input bit v, input bit we, input logic [4:0] addr, input logic [W-1:0] d);
        b_valid = v; b_we = we; b_addr = addr; b_wdata = d;
    endtask

    task automatic idle_in();
        set_a(0, 0, 0, '0);
        set_b(0, 0, 0, '0);
    endtask

    // one cycle: check handshake against the model, update the scoreboard, advance, check read returns
    task automatic step();
        logic ea, eb;
        rd_t r;
        #1;
        ea = act & !shutdown_req & !rst;
        eb = ea & !(a_valid & b_valid & (a_addr == b_addr) & (a_we | b_we));
        chkb("a_ready", a_ready, ea);
        chkb("b_ready", b_ready, eb);
        if (a_valid && ea && !a_we) begin r.due = cyc + 2; r.d = ref_mem[a_addr]; r.ok = ref_ok[a_addr]; qa.push_back(r); end
        if (b_valid && eb && !b_we) begin r.due = cyc + 2; r.d = ref_mem[b_addr]; r.ok = ref_ok[b_addr]; qb.push_back(r); end
        if (a_valid && ea && a_we) begin ref_mem[a_addr] = a_wdata; ref_ok[a_addr] = 1; end
        if (b_valid && eb && b_we) begin ref_mem[b_addr] = b_wdata; ref_ok[b_addr] = 1; end
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin qa.delete(); qb.delete(); end
        ea = qa.size() > 0 && qa[0].due == cyc;
        chkb("a_rvalid", a_rvalid, ea);
        if (ea) begin r = qa.pop_front(); if (r.ok) chkw("a_rdata", a_rdata, r.d); end
        eb = qb.size() > 0 && qb[0].due == cyc;
        chkb("b_rvalid", b_rvalid, eb);
        if (eb) begin r = qb.pop_front(); if (r.ok) chkw("b_rdata", b_rdata, r.d); end
    endtask

    task automatic chk_st(input logic [2:0] s);
        chkn("pwr_state", 8'(pwr_state), 8'(s));
        chkb("m_ls", m_ls, s == 3'd1);
        chkb("m_ds", m_ds, s == 3'd2);
        chkb("m_sd", m_sd, s == 3'd3);
        if (s != 3'd0) begin
            chkb("csb1_sleep", m_csb1, 1'b1);
            chkb("csb2_sleep", m_csb2, 1'b1);
        end
    endtask

    // idle from an accept until the idle rules settle: light sleep after 8, deep sleep after 64
    task automatic idle64();
        idle_in();
        for (int i = 1; i <= 64; i++) begin
            act = (i <= 8);
            step();
            if (i == 32) chk_st(3'd1);
        end
        act = 0;
`ifdef LP_DMEM_CTRL_DS_EN
        chk_st(3'd2);
`else
        chk_st(3'd1);
`endif
    endtask

    initial begin
        logic [W-1:0] pat, da, db, dc;
        bit av, aw, bv, bw;
        int run;
        pat = {(W/8){8'hA5}};
        da = {$urandom, $urandom};
        db = {$urandom, $urandom};
        dc = {$urandom, $urandom};
        rst = 1; shutdown_req = 0; act = 0;
        idle_in();
        step();
        step();
        chk_st(3'd0);
        chkb("rst_csb1", m_csb1, 1'b1);
        chkb("rst_web1", m_web1, 1'b1);
        chkb("rst_oeb2", m_oeb2, 1'b1);
        chkn("rst_a1", 8'(m_a1), 8'd0);
        chkw("rst_i1", m_i1, '0);
        chkb("rst_lost", mem_lost, 1'b0);
        rst = 0; act = 1;
        // write then read back on client A
        set_a(1, 1, 5, pat);
        step();
        chkb("wr_web1", m_web1, 1'b0);
        chkn("wr_a1", 8'(m_a1), 8'd5);
        chkw("wr_i1", m_i1, pat);
        set_a(1, 0, 5, '0);
        step();
        chkb("rd_web1", m_web1, 1'b1);
        chkb("rd_oeb1", m_oeb1, 1'b0);
        idle_in();
        step();
        step();
        // same-address write conflict: A wins, B follows
        set_a(1, 1, 3, da);
        set_b(1, 1, 3, db);
        step();
        chkb("conf_csb1", m_csb1, 1'b0);
        chkb("conf_csb2", m_csb2, 1'b1);
        set_a(0, 0, 0, '0);
        step();
        chkb("b_acc_csb2", m_csb2, 1'b0);
        set_b(0, 0, 0, '0);
        set_a(1, 0, 3, '0);
        step();
        // light sleep after 8 idle cycles, woken by a request
        idle_in();
        repeat (7) step();
        chk_st(3'd0);
        step();
        act = 0;
        chk_st(3'd1);
        set_a(1, 0, 5, '0);
        step();
        act = 1;
        chk_st(3'd0);
        step();
        idle64();
        set_a(1, 0, 3, '0);
`ifdef LP_DMEM_CTRL_DS_EN
        step();
        chk_st(3'd4);
        step();
        chk_st(3'd4);
        step();
`else
        step();
`endif
        act = 1;
        chk_st(3'd0);
        step();
        // shutdown pulse while a read is in flight
        set_a(1, 0, 5, '0);
        step();
        idle_in();
        shutdown_req = 1;
        step();
        act = 0;
        chk_st(3'd3);
        chkb("sd_lost", mem_lost, 1'b1);
        for (int k = 0; k < 32; k++) ref_ok[k] = 0;
        shutdown_req = 0;
        step();
        chk_st(3'd4);
        repeat (3) begin
            step();
            chk_st(3'd4);
        end
        step();
        act = 1;
        chk_st(3'd0);
        chkb("wake_lost", mem_lost, 1'b1);
        set_a(1, 0, 3, '0);
        set_b(1, 1, 7, dc);
        step();
        chkb("wr_clr_lost", mem_lost, 1'b0);
        set_b(0, 0, 0, '0);
        set_a(1, 0, 7, '0);
        step();
        // reset from the deepest idle state
        idle64();
        rst = 1;
        step();
        chk_st(3'd0);
        chkb("rst2_csb1", m_csb1, 1'b1);
        chkn("rst2_a1", 8'(m_a1), 8'd0);
        chkw("rst2_i1", m_i1, '0);
        chkb("rst2_lost", mem_lost, 1'b0);
        rst = 0;
        act = 1;
        // random traffic kept busy enough to stay in ACTIVE
        run = 0;
        repeat (400) begin
            av = (run >= 5) ? 1'b1 : ($urandom_range(3) != 0);
            bv = $urandom_range(3) != 0;
            aw = 1'($urandom_range(1));
            bw = 1'($urandom_range(1));
            set_a(av, aw, 5'($urandom_range(7)), {$urandom, $urandom});
            set_b(bv, bw, 5'($urandom_range(7)), {$urandom, $urandom});
            run = av ? 0 : run + 1;
            step();
        end
        // reset with a read in flight drops its rvalid
        set_a(1, 0, 2, '0);
        set_b(0, 0, 0, '0);
        step();
        idle_in();
        rst = 1;
        step();
        rst = 0;
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/lp_dmem_ctrl.md
# lp_dmem_ctrl

Access and power-mode controller for the dual-port low-power data memory (NUM_BANK × 32-bit banks, 32 words, ports 1/2). It gives two datapath clients (client A → SRAM port 1, client B → SRAM port 2) a valid/ready interface and drives every SRAM pin except the clock (CE1/CE2 are tied to clk at the top level). It resolves same-address conflicts between the two clients and sequences the shared SD/DS/LS pins: idle-driven light and deep sleep, requested shutdown, and the wake-up delays between them.

## Interface
Parameters:
- NUM_BANK, 48, banks per word; data width W = 32*NUM_BANK
- LS_IDLE, 8, consecutive idle cycles before light sleep
- DS_IDLE, 64, consecutive idle cycles before deep sleep; must be greater than LS_IDLE
- WAKE_DS, 2, wake cycles after deep sleep
- WAKE_SD, 4, wake cycles after shutdown
- CNT_W, 8, width of the idle and wake counters

Ports:
- clk  in  1  clock; also drives SRAM CE1/CE2
- rst  in  1  synchronous, active-high reset
- a_valid / b_valid  in  1  request valid
- a_ready / b_ready  out  1  request accepted when valid&ready
- a_we / b_we  in  1  1 = write, 0 = read
- a_addr / b_addr  in  5  word address
- a_wdata / b_wdata  in  W  write data
- a_rdata / b_rdata  out  W  read data; direct from O1 / O2
- a_rvalid / b_rvalid  out  1  read data valid
- shutdown_req  in  1  level request for shutdown (contents lost)
- pwr_state  out  3  current FSM state
- mem_lost  out  1  contents invalid since the last shutdown
- m_sd, m_ds, m_ls  out  1  drive SD1/SD2, DS1/DS2, LS1/LS2 (shared by both ports)
- m_csb1/2, m_web1/2, m_oeb1/2  out  1  active-low chip select, write enable, output enable
- m_a1/2  out  5  SRAM address
- m_i1/2  out  W  SRAM write data
- m_o1/2  in  W  SRAM read data

## Operation
- FSM states: ACTIVE=0, LSLP=1, DSLP=2, SHDN=3, WAKE=4.
- Ready rule: a_ready = (state==ACTIVE) & !shutdown_req. b_ready is the same, AND-ed with no conflict.
- Conflict: a_valid & b_valid & equal addresses & (a_we | b_we). Client A wins. b_ready is low that cycle.
- Accept: registered pins for the next cycle are csb=0, web=!we, oeb=we, a=addr, i=wdata.
- Non-accept: csb=1, web=1, oeb=1. Address and data hold their previous values.
- Idle counter:
  - Cleared on any accept, and in every state other than ACTIVE/LSLP.
  - Otherwise increments while in ACTIVE/LSLP, saturating at DS_IDLE.
- Transitions:
  - ACTIVE → LSLP: idle count reaches LS_IDLE.
  - LSLP → DSLP: idle count reaches DS_IDLE.
  - LSLP → ACTIVE: any valid. Ready stays low in the LSLP cycle.
  - DSLP → WAKE: any valid. Wake counter loads WAKE_DS.
  - any state → SHDN: shutdown_req. Takes priority over all other transitions.
  - SHDN → WAKE: shutdown_req deasserted. Wake counter loads WAKE_SD.
  - WAKE → ACTIVE: wake counter reaches 0 (decrements by 1 per cycle). shutdown_req during WAKE → SHDN.
- Power pins:
  - m_ls=1 in LSLP only.
  - m_ds=1 in DSLP only.
  - m_sd=1 in SHDN only.
  - All three are 0 in WAKE and ACTIVE.
  - csb=1 in every state except ACTIVE.
- mem_lost: set on entry to SHDN; cleared by the first accepted write on either client.

## Timing
- Reset values:
  - pwr_state=ACTIVE; idle and wake counters 0.
  - m_csb/m_web/m_oeb=1; m_sd/m_ds/m_ls=0; m_a=0, m_i=0.
  - rvalid=0, mem_lost=0, ready=0 while rst is high.
- Reset mid-operation: rst forces the reset values on the next edge, from any state. In-flight rvalid is dropped.
- Read latency is 2 cycles:
  - Accept in cycle T; pins registered at the end of T.
  - SRAM samples them at the end of T+1.
  - rvalid=1 and rdata valid during T+2.
- Write: SRAM commits it at the end of T+1.
- Throughput: 1 request per client per cycle while in ACTIVE.
- Read after write to the same address on the same client in back-to-back cycles returns the new data.
- A request pending when a sleep transition fires is not lost. valid stays high, and the client wakes the FSM.
- shutdown_req arriving while reads are in flight: the in-flight rvalid still completes. The shutdown register stage makes sure csb=1 before m_sd rises.

## Configuration
- LP_DMEM_CTRL_DS_EN defined: full FSM as above.
- Undefined:
  - DSLP is unreachable; LSLP persists indefinitely.
  - m_ds is tied to 0; WAKE_DS is unused.
  - The idle counter saturates at LS_IDLE.

## Structure
- Package lp_dmem_pkg holds:
  - the state enum (values above);
  - default constants NUM_BANK, LS_IDLE, DS_IDLE, WAKE_DS, WAKE_SD;
  - the pin-idle constants.
- Sub-module lp_dmem_port_seq holds the per-port pin register stage and the 2-deep rvalid pipe. It is instantiated twice. The FSM, conflict logic and idle/wake counters stay in the top.

## Test plan
- Write A addr 5 = 0xA5 pattern, then read A addr 5 → a_rvalid 2 cycles after accept with the pattern. m_web1=0 for exactly one cycle.
- A and B both write addr 3 in the same cycle → A accepted, b_ready=0. B is accepted the next cycle, and the final read returns B's data.
- No requests for 8 cycles → pwr_state=LSLP, m_ls=1. A request → ACTIVE after 1 cycle and is accepted there.
- 64 idle cycles → DSLP, m_ds=1. A request → WAKE for 2 cycles, then accepted. Repeat with the macro undefined: m_ds never rises.
- shutdown_req pulse during a read → that rvalid still completes. Then SHDN with m_sd=1 and mem_lost=1, then WAKE for 4 cycles. mem_lost clears on the first write.
- rst asserted in DSLP → next cycle ACTIVE with all pins at their reset values.
